minmax_tracker: RTL and testbench
=================================

MINMAX_TRACKER -- requirements
Module: minmax_tracker

Interface
REQ-001 SHALL have parameter N, default 4: sample width in bits, unsigned.
REQ-002 SHALL have parameter CNT_W, default 8: width of the frame sample counter.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port in_valid, input, 1: in_data and in_last are valid.
REQ-006 SHALL have port in_ready, output, 1: block accepts a sample this cycle.
REQ-007 SHALL have port in_data, input, N: sample value.
REQ-008 SHALL have port in_last, input, 1: current sample ends the frame.
REQ-009 SHALL have port out_valid, output, 1: frame result is available.
REQ-010 SHALL have port out_ready, input, 1: downstream consumes the result.
REQ-011 SHALL have port out_max, output, N: largest sample of the frame.
REQ-012 SHALL have port out_min, output, N: smallest sample of the frame.
REQ-013 SHALL have port out_cnt, output, CNT_W: number of samples in the frame, saturating.
REQ-014 SHALL have port out_eq, output, 1: out_max equals out_min.

Function
REQ-015 SHALL define an input transfer as in_valid && in_ready on a rising clk edge, and an output transfer as out_valid && out_ready on a rising clk edge.
REQ-016 SHALL implement states IDLE (no sample held), ACC (frame open) and HOLD (result pending), with in_ready = 1 in IDLE/ACC and 0 in HOLD.
REQ-017 SHALL, on a transfer in IDLE, load max = min = in_data and cnt = 1, then go to ACC, or to HOLD if in_last = 1.
REQ-018 SHALL, on a transfer in ACC, set max = in_data only if in_data > max, set min = in_data only if in_data < min, and set cnt = cnt + 1.
REQ-019 SHALL compare samples unsigned, MSB first; ties SHALL NOT update max or min.
REQ-020 SHALL saturate cnt at 2^CNT_W-1; further samples in the frame SHALL still update max and min.
REQ-021 SHALL leave ACC for HOLD on the transfer with in_last = 1, using that sample in the result.
REQ-022 SHALL register all outputs, so out_valid rises exactly 1 cycle after the in_last transfer.
REQ-023 SHALL keep out_max, out_min, out_cnt and out_eq stable while out_valid = 1 and out_ready = 0.
REQ-024 SHALL, on an output transfer, go to IDLE and deassert out_valid on the next cycle; the next frame SHALL start no earlier than the cycle after the output transfer (1-cycle bubble).
REQ-025 SHALL hold state with no change in cycles without a transfer, including in_valid = 0 mid-frame.

Reset
REQ-026 SHALL, while rst = 1, drive in_ready = 0 and force state IDLE.
REQ-027 SHALL, while rst = 1, force out_valid, out_max, out_min, out_cnt and out_eq to 0.
REQ-028 SHALL give rst priority over all transfers.
REQ-029 SHALL discard a partial frame or pending result when rst is asserted mid-operation, with no result emitted for it.

Configuration
REQ-030 SHALL, with macro MINMAX_TRACKER_INDEX_EN defined, add outputs out_max_idx and out_min_idx (CNT_W each).
REQ-031 SHALL set each index to the 0-based position of the first occurrence of the max or min value in the frame.
REQ-032 SHALL freeze both indices at 2^CNT_W-1 once cnt saturates, and reset both indices to 0.
REQ-033 SHALL, without MINMAX_TRACKER_INDEX_EN, omit these ports and their logic entirely, with all other behaviour identical.

Verification (N=4, CNT_W=8 unless stated)
REQ-034 SHALL cover frame 3,9,1,9(last) -> out_max=9, out_min=1, out_cnt=4, out_eq=0; with INDEX_EN, max_idx=1, min_idx=2.
REQ-035 SHALL cover single sample 5 with in_last=1 from IDLE -> out_max=5, out_min=5, out_cnt=1, out_eq=1, out_valid one cycle later.
REQ-036 SHALL cover frame 7,7,7(last) -> out_eq=1, out_cnt=3; with INDEX_EN, both indices 0.
REQ-037 SHALL cover out_ready held low for 3 cycles after a result -> outputs stable, in_ready=0 throughout; out_ready=1 -> out_valid low next cycle, in_ready=1.
REQ-038 SHALL cover CNT_W=2 with frame 1,2,3,4,15(last) -> out_cnt=3, out_max=15, out_min=1.
REQ-039 SHALL cover rst pulse after samples 2,8 of an open frame, then frame 6(last) -> only one result: out_max=6, out_min=6, out_cnt=1.

Source files
------------

// File: rtl/minmax_tracker.sv
// Frame min/max tracker: accumulates unsigned samples until in_last, then holds the result for a ready/valid consumer.
// Optional feature: define MINMAX_TRACKER_INDEX_EN to add first-occurrence index outputs for max and min.
module minmax_tracker #(
  parameter int N     = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_max,
  output logic [N-1:0]     out_min,
  output logic [CNT_W-1:0] out_cnt,
  output logic             out_eq
`ifdef MINMAX_TRACKER_INDEX_EN
  ,
  output logic [CNT_W-1:0] out_max_idx,
  output logic [CNT_W-1:0] out_min_idx
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    HOLD
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state, state_nxt;
  logic [N-1:0]     acc_max, acc_min, max_nxt, min_nxt;
  logic [CNT_W-1:0] acc_cnt, cnt_nxt;
  logic             in_xfer, out_xfer, load_out;

  assign in_ready = !rst && (state != HOLD);
  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;

  always_comb begin
    state_nxt = state;
    max_nxt   = acc_max;
    min_nxt   = acc_min;
    cnt_nxt   = acc_cnt;
    load_out  = 1'b0;
    case (state)
      IDLE: begin
        if (in_xfer) begin
          max_nxt   = in_data;
          min_nxt   = in_data;
          cnt_nxt   = CNT_W'(1);
          state_nxt = in_last ? HOLD : ACC;
          load_out  = in_last;
        end
      end
      ACC: begin
        if (in_xfer) begin
          if (in_data > acc_max) max_nxt = in_data;
          if (in_data < acc_min) min_nxt = in_data;
          // count saturates but extremes keep tracking
          if (acc_cnt != CNT_MAX) cnt_nxt = acc_cnt + CNT_W'(1);
          if (in_last) begin
            state_nxt = HOLD;
            load_out  = 1'b1;
          end
        end
      end
      HOLD: begin
        if (out_xfer) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      acc_max   <= '0;
      acc_min   <= '0;
      acc_cnt   <= '0;
      out_valid <= 1'b0;
      out_max   <= '0;
      out_min   <= '0;
      out_cnt   <= '0;
      out_eq    <= 1'b0;
    end else begin
      state   <= state_nxt;
      acc_max <= max_nxt;
      acc_min <= min_nxt;
      acc_cnt <= cnt_nxt;
      if (load_out) begin
        out_valid <= 1'b1;
        out_max   <= max_nxt;
        out_min   <= min_nxt;
        out_cnt   <= cnt_nxt;
        out_eq    <= (max_nxt == min_nxt);
      end else if (out_xfer) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef MINMAX_TRACKER_INDEX_EN
  logic [CNT_W-1:0] acc_max_idx, acc_min_idx, max_idx_nxt, min_idx_nxt;

  // Unsaturated count equals the 0-based position of the incoming sample
  always_comb begin
    max_idx_nxt = acc_max_idx;
    min_idx_nxt = acc_min_idx;
    if (in_xfer) begin
      if (state == IDLE) begin
        max_idx_nxt = '0;
        min_idx_nxt = '0;
      end else begin
        if (in_data > acc_max) max_idx_nxt = acc_cnt;
        if (in_data < acc_min) min_idx_nxt = acc_cnt;
      end
      if (cnt_nxt == CNT_MAX) begin
        max_idx_nxt = CNT_MAX;
        min_idx_nxt = CNT_MAX;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_max_idx <= '0;
      acc_min_idx <= '0;
      out_max_idx <= '0;
      out_min_idx <= '0;
    end else begin
      acc_max_idx <= max_idx_nxt;
      acc_min_idx <= min_idx_nxt;
      if (load_out) begin
        out_max_idx <= max_idx_nxt;
        out_min_idx <= min_idx_nxt;
      end
    end
  end
`endif

endmodule

// File: tb/tb_minmax_tracker.sv
// Bench for minmax_tracker: two instances (CNT_W=8 and CNT_W=2) share stimulus and are checked against a frame-level queue model.
module tb_minmax_tracker;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [3:0] in_data = '0;
  logic       in_last = 1'b0;
  logic       out_ready = 1'b0;

  logic       in_ready_a, out_valid_a, out_eq_a;
  logic [3:0] out_max_a, out_min_a;
  logic [7:0] out_cnt_a;
  logic       in_ready_b, out_valid_b, out_eq_b;
  logic [3:0] out_max_b, out_min_b;
  logic [1:0] out_cnt_b;
`ifdef MINMAX_TRACKER_INDEX_EN
  logic [7:0] out_max_idx_a, out_min_idx_a;
  logic [1:0] out_max_idx_b, out_min_idx_b;
`endif

  int test_count = 0;
  int fail_count = 0;

  // frame-level reference model state
  logic [3:0] frame_q[$];
  bit         pending = 0;
  bit         rst_last = 1;
  logic [3:0] exp_max, exp_min;
  logic       exp_eq;
  logic [7:0] exp_cnt_a, exp_max_idx_a, exp_min_idx_a;
  logic [1:0] exp_cnt_b, exp_max_idx_b, exp_min_idx_b;

  always #5 clk = ~clk;

  minmax_tracker #(.N(4), .CNT_W(8)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid_a),
    .out_ready(out_ready), .out_max(out_max_a), .out_min(out_min_a),
    .out_cnt(out_cnt_a), .out_eq(out_eq_a)
`ifdef MINMAX_TRACKER_INDEX_EN
    , .out_max_idx(out_max_idx_a), .out_min_idx(out_min_idx_a)
`endif
  );

  minmax_tracker #(.N(4), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid_b),
    .out_ready(out_ready), .out_max(out_max_b), .out_min(out_min_b),
    .out_cnt(out_cnt_b), .out_eq(out_eq_b)
`ifdef MINMAX_TRACKER_INDEX_EN
    , .out_max_idx(out_max_idx_b), .out_min_idx(out_min_idx_b)
`endif
  );

  task automatic check_value(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    test_count++;
    assert (observed === expected) else begin
      fail_count++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Result of a completed frame: first occurrence wins on ties, count and indices saturate
  task automatic compute_result();
    int sz, mi, ni;
    sz = frame_q.size();
    exp_max = frame_q[0];
    exp_min = frame_q[0];
    mi = 0;
    ni = 0;
    for (int i = 1; i < sz; i++) begin
      if (frame_q[i] > exp_max) begin exp_max = frame_q[i]; mi = i; end
      if (frame_q[i] < exp_min) begin exp_min = frame_q[i]; ni = i; end
    end
    exp_eq        = (exp_max == exp_min);
    exp_cnt_a     = (sz > 255) ? 8'd255 : 8'(sz);
    exp_cnt_b     = (sz > 3) ? 2'd3 : 2'(sz);
    exp_max_idx_a = (sz >= 255) ? 8'hFF : 8'(mi);
    exp_min_idx_a = (sz >= 255) ? 8'hFF : 8'(ni);
    exp_max_idx_b = (sz >= 3) ? 2'b11 : 2'(mi);
    exp_min_idx_b = (sz >= 3) ? 2'b11 : 2'(ni);
  endtask

  task automatic checkOutput();
    check_value("out_valid_a", 32'(out_valid_a), 32'(pending));
    check_value("out_valid_b", 32'(out_valid_b), 32'(pending));
    if (pending || rst_last) begin
      check_value("out_max_a", 32'(out_max_a), 32'(exp_max));
      check_value("out_min_a", 32'(out_min_a), 32'(exp_min));
      check_value("out_cnt_a", 32'(out_cnt_a), 32'(exp_cnt_a));
      check_value("out_eq_a", 32'(out_eq_a), 32'(exp_eq));
      check_value("out_max_b", 32'(out_max_b), 32'(exp_max));
      check_value("out_min_b", 32'(out_min_b), 32'(exp_min));
      check_value("out_cnt_b", 32'(out_cnt_b), 32'(exp_cnt_b));
      check_value("out_eq_b", 32'(out_eq_b), 32'(exp_eq));
`ifdef MINMAX_TRACKER_INDEX_EN
      check_value("max_idx_a", 32'(out_max_idx_a), 32'(exp_max_idx_a));
      check_value("min_idx_a", 32'(out_min_idx_a), 32'(exp_min_idx_a));
      check_value("max_idx_b", 32'(out_max_idx_b), 32'(exp_max_idx_b));
      check_value("min_idx_b", 32'(out_min_idx_b), 32'(exp_min_idx_b));
`endif
    end
  endtask

  // One clock: drive inputs, predict the edge at the falling edge, check just after the rising edge
  task automatic applyStimulus(input logic r, input logic v, input logic [3:0] d,
                               input logic l, input logic rdy);
    rst       = r;
    in_valid  = v;
    in_data   = d;
    in_last   = l;
    out_ready = rdy;
    @(negedge clk);
    check_value("in_ready_a", 32'(in_ready_a), 32'(!r && !pending));
    check_value("in_ready_b", 32'(in_ready_b), 32'(!r && !pending));
    if (r) begin
      frame_q.delete();
      pending  = 0;
      rst_last = 1;
      exp_max = '0; exp_min = '0; exp_eq = 1'b0;
      exp_cnt_a = '0; exp_cnt_b = '0;
      exp_max_idx_a = '0; exp_min_idx_a = '0;
      exp_max_idx_b = '0; exp_min_idx_b = '0;
    end else begin
      rst_last = 0;
      if (pending) begin
        if (rdy) pending = 0;
      end else if (v) begin
        frame_q.push_back(d);
        if (l) begin
          compute_result();
          frame_q.delete();
          pending = 1;
        end
      end
    end
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic send(input logic [3:0] d, input logic l);
    applyStimulus(1'b0, 1'b1, d, l, 1'b0);
  endtask

  task automatic drain(input int hold_cycles);
    repeat (hold_cycles) applyStimulus(1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
  endtask

  initial begin
    // reset, including a sample offered while reset is held
    applyStimulus(1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 4'd5, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0, 4'd0, 1'b0, 1'b0);

    // single-sample frame, then consumer stalls for three cycles
    send(4'd5, 1'b1);
    check_value("single_max", 32'(out_max_a), 32'd5);
    check_value("single_eq", 32'(out_eq_a), 32'd1);
    check_value("single_cnt", 32'(out_cnt_a), 32'd1);
    drain(3);
    applyStimulus(1'b0, 1'b0, 4'd0, 1'b0, 1'b0);

    // 3,9,1,9 with a tie on the max
    send(4'd3, 1'b0); send(4'd9, 1'b0); send(4'd1, 1'b0); send(4'd9, 1'b1);
    check_value("f1_max", 32'(out_max_a), 32'd9);
    check_value("f1_min", 32'(out_min_a), 32'd1);
    check_value("f1_cnt", 32'(out_cnt_a), 32'd4);
    check_value("f1_eq", 32'(out_eq_a), 32'd0);
`ifdef MINMAX_TRACKER_INDEX_EN
    check_value("f1_max_idx", 32'(out_max_idx_a), 32'd1);
    check_value("f1_min_idx", 32'(out_min_idx_a), 32'd2);
`endif
    drain(1);

    // all-equal frame
    send(4'd7, 1'b0); send(4'd7, 1'b0); send(4'd7, 1'b1);
    check_value("f2_eq", 32'(out_eq_a), 32'd1);
    check_value("f2_cnt", 32'(out_cnt_a), 32'd3);
    drain(0);

    // saturating count on the narrow instance, with an idle gap mid-frame
    send(4'd1, 1'b0); send(4'd2, 1'b0);
    applyStimulus(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
    send(4'd3, 1'b0); send(4'd4, 1'b0); send(4'd15, 1'b1);
    check_value("f3_cnt_b", 32'(out_cnt_b), 32'd3);
    check_value("f3_max_b", 32'(out_max_b), 32'd15);
    check_value("f3_min_b", 32'(out_min_b), 32'd1);
    drain(2);

    // reset discards an open frame
    send(4'd2, 1'b0); send(4'd8, 1'b0);
    applyStimulus(1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
    send(4'd6, 1'b1);
    check_value("f4_max", 32'(out_max_a), 32'd6);
    check_value("f4_min", 32'(out_min_a), 32'd6);
    check_value("f4_cnt", 32'(out_cnt_a), 32'd1);
    drain(1);

    // long frame saturating the wide instance
    for (int i = 0; i < 299; i++) send(4'($urandom_range(0, 15)), 1'b0);
    send(4'($urandom_range(0, 15)), 1'b1);
    drain(1);

    // random traffic: gaps, backpressure, offers during hold, occasional reset
    for (int i = 0; i < 800; i++) begin
      applyStimulus(1'($urandom_range(0, 60) == 0), 1'($urandom_range(0, 3) != 0),
                    4'($urandom_range(0, 15)), 1'($urandom_range(0, 3) == 0),
                    1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
    $finish;
  end

endmodule
